// File: rtl/lfsr_scrambler_par.sv
// ---------------------------------------------------------------------------
// lfsr_scrambler_par
//   Parallel LFSR scrambler/descrambler. DATA_W bits per clock pass through
//   a Fibonacci LFSR. The bit-serial recurrence is unrolled combinationally,
//   with bit 0 as the earliest bit in serial time.
//   MODE 0 : additive (frame-synchronous) scramble/descramble
//   MODE 1 : multiplicative (self-synchronising) scramble
//   MODE 2 : multiplicative descramble
//
// Ports
//   Clk          clock
//   Reset        synchronous, active-high reset
//   seed_load    strobe: seed_in -> seed register and LFSR at the next edge
//   seed_in      runtime seed value (LFSR_LEN bits)
//   frame_start  with an accepted word: process that word from the seed register
//   in_valid     input word valid
//   in_ready     block can accept a word this cycle (combinational)
//   in_data      input word (DATA_W bits)
//   out_valid    registered output word valid
//   out_ready    downstream accepts the output word
//   out_data     registered processed word (DATA_W bits)
//   word_cnt     words emitted since Reset / last accepted frame_start
// ---------------------------------------------------------------------------
module lfsr_scrambler_par #(
  parameter int                  DATA_W   = 8,
  parameter int                  LFSR_LEN = 7,
  parameter logic [LFSR_LEN-1:0] POLY     = 7'b1001000,
  parameter logic [LFSR_LEN-1:0] SEED     = 7'h7F,
  parameter int                  MODE     = 0
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                seed_load,
  input  logic [LFSR_LEN-1:0] seed_in,
  input  logic                frame_start,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_data,
  output logic [15:0]         word_cnt
);

  localparam logic [1:0] MODE_SEL  = MODE[1:0];
  localparam logic [1:0] MODE_ADD  = 2'd0;
  localparam logic [1:0] MODE_MSCR = 2'd1;
  localparam logic [1:0] MODE_MDSC = 2'd2;

  logic [LFSR_LEN-1:0] lfsr_r;
  logic [LFSR_LEN-1:0] seed_val_r;
  logic                out_valid_r;
  logic [DATA_W-1:0]   out_data_r;
  logic [15:0]         word_cnt_r;

  logic                in_ready_s;
  logic                accept_s;
  logic                xfer_s;
  logic [LFSR_LEN-1:0] start_state_s;
  logic [LFSR_LEN-1:0] next_state_s;
  logic [DATA_W-1:0]   proc_data_s;

  // Feedback bit: XOR parity of the tapped LFSR stages.
  function automatic logic feedback_bit(input logic [LFSR_LEN-1:0] st);
    return ^(st & POLY);
  endfunction

  // Run the serial recurrence over one word; returns {final_state, word_out}.
  function automatic logic [LFSR_LEN+DATA_W-1:0] scramble_word(
    input logic [LFSR_LEN-1:0] st,
    input logic [DATA_W-1:0]   din
  );
    logic [LFSR_LEN-1:0] s;
    logic [DATA_W-1:0]   o;
    logic                f;
    logic                nb;
    s = st;
    o = '0;
    for (int j = 0; j < DATA_W; j++) begin
      f    = feedback_bit(s);
      o[j] = din[j] ^ f;
      // The bit shifted into the register is what distinguishes the modes.
      case (MODE_SEL)
        MODE_ADD:  nb = f;
        MODE_MSCR: nb = o[j];
        MODE_MDSC: nb = din[j];
        default:   nb = f;
      endcase
      s = {s[LFSR_LEN-2:0], nb};
    end
    return {s, o};
  endfunction

  assign in_ready_s = !out_valid_r || out_ready;
  assign accept_s   = in_valid && in_ready_s;
  assign xfer_s     = out_valid_r && out_ready;

  // Pick the starting state (seed register on frame_start) and process the word.
  always_comb begin
    start_state_s = lfsr_r;
    if (frame_start) begin
      start_state_s = seed_val_r;
    end else begin
      start_state_s = lfsr_r;
    end
    {next_state_s, proc_data_s} = scramble_word(start_state_s, in_data);
  end

  // LFSR and seed register: seed_load overrides the advance of an accepted word.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      lfsr_r     <= SEED;
      seed_val_r <= SEED;
    end else if (seed_load) begin
      lfsr_r     <= seed_in;
      seed_val_r <= seed_in;
    end else if (accept_s) begin
      lfsr_r     <= next_state_s;
    end
  end

  // Single registered output stage; holds while stalled.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
    end else if (accept_s) begin
      out_valid_r <= 1'b1;
      out_data_r  <= proc_data_s;
    end else if (xfer_s) begin
      out_valid_r <= 1'b0;
    end
  end

  // Emitted-word counter. A frame-start word restarts it at 0 so that it
  // reads 1 once that word has been emitted; an older word leaving in the
  // same cycle belongs to the previous frame.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      word_cnt_r <= 16'd0;
    end else if (accept_s && frame_start) begin
      word_cnt_r <= 16'd0;
    end else if (xfer_s) begin
      word_cnt_r <= word_cnt_r + 16'd1;
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign word_cnt  = word_cnt_r;

endmodule

// File: tb/tb_lfsr_scrambler_par.sv
module tb_lfsr_scrambler_par;

  localparam int NI = 4;  // 0,1: additive; 2: mult scramble; 3: mult descramble

  logic       Clk = 1'b0;
  logic       rst         [NI];
  logic       seed_load   [NI];
  logic [6:0] seed_in     [NI];
  logic       frame_start [NI];
  logic       in_valid    [NI];
  logic       in_ready    [NI];
  logic [7:0] in_data     [NI];
  logic       out_valid   [NI];
  logic       out_ready   [NI];
  logic [7:0] out_data    [NI];
  logic [15:0] word_cnt   [NI];

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] src_q[$];
  logic [7:0] got_q[$];
  logic [7:0] orig_q[$];
  logic [7:0] scr_q[$];

  always #5 Clk = ~Clk;

  lfsr_scrambler_par #(.MODE(0)) u_add_a (
    .Clk(Clk), .Reset(rst[0]), .seed_load(seed_load[0]), .seed_in(seed_in[0]),
    .frame_start(frame_start[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_data(in_data[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_data(out_data[0]), .word_cnt(word_cnt[0]));

  lfsr_scrambler_par #(.MODE(0)) u_add_b (
    .Clk(Clk), .Reset(rst[1]), .seed_load(seed_load[1]), .seed_in(seed_in[1]),
    .frame_start(frame_start[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_data(in_data[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_data(out_data[1]), .word_cnt(word_cnt[1]));

  lfsr_scrambler_par #(.MODE(1)) u_mscr (
    .Clk(Clk), .Reset(rst[2]), .seed_load(seed_load[2]), .seed_in(seed_in[2]),
    .frame_start(frame_start[2]), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in_data(in_data[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
    .out_data(out_data[2]), .word_cnt(word_cnt[2]));

  lfsr_scrambler_par #(.MODE(2)) u_mdsc (
    .Clk(Clk), .Reset(rst[3]), .seed_load(seed_load[3]), .seed_in(seed_in[3]),
    .frame_start(frame_start[3]), .in_valid(in_valid[3]), .in_ready(in_ready[3]),
    .in_data(in_data[3]), .out_valid(out_valid[3]), .out_ready(out_ready[3]),
    .out_data(out_data[3]), .word_cnt(word_cnt[3]));

  // Directed vector record: inputs for one cycle and the outputs after the edge.
  typedef struct {
    logic       iv;
    logic [7:0] id;
    logic       ordy;
    logic       fs;
    logic       sl;
    logic [6:0] si;
    logic       ov;
    logic [7:0] od;
    logic [15:0] cnt;
  } vec_t;

  vec_t tbl[18];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: x^7+x^4+1 written out directly, one bit at a time.
  function automatic logic [14:0] mdl_step(input int mode, input logic [6:0] st,
                                           input logic [7:0] d);
    logic [6:0] s;
    logic [7:0] o;
    logic fb;
    logic nb;
    s = st;
    o = 8'h00;
    for (int j = 0; j < 8; j++) begin
      fb   = s[6] ^ s[3];
      o[j] = d[j] ^ fb;
      nb   = (mode == 0) ? fb : ((mode == 1) ? o[j] : d[j]);
      s    = {s[5:0], nb};
    end
    return {s, o};
  endfunction

  task automatic idle_inputs(input int k);
    seed_load[k]   = 1'b0;
    seed_in[k]     = 7'h00;
    frame_start[k] = 1'b0;
    in_valid[k]    = 1'b0;
    in_data[k]     = 8'h00;
    out_ready[k]   = 1'b1;
  endtask

  task automatic do_reset(input int k);
    @(negedge Clk);
    idle_inputs(k);
    rst[k] = 1'b1;
    @(negedge Clk);
    rst[k] = 1'b0;
  endtask

  // Stream src_q through instance k, collecting transferred words in got_q.
  task automatic run_stream(input int k, input int n, input bit rand_rdy, input bit fs0);
    int sent;
    int cyc;
    bit hold;
    logic [7:0] held;
    sent = 0;
    cyc  = 0;
    hold = 1'b0;
    held = 8'h00;
    got_q.delete();
    while (got_q.size() < n && cyc < 5000) begin
      @(negedge Clk);
      if (hold) begin
        check("stall_valid", {31'd0, out_valid[k]}, 32'd1);
        check("stall_data", {24'd0, out_data[k]}, {24'd0, held});
      end
      in_valid[k]    = (sent < n);
      in_data[k]     = (sent < n) ? src_q[sent] : 8'h00;
      frame_start[k] = fs0 && (sent == 0);
      out_ready[k]   = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (out_valid[k] && out_ready[k]) got_q.push_back(out_data[k]);
      hold = out_valid[k] && !out_ready[k];
      held = out_data[k];
      if (in_valid[k] && in_ready[k]) sent++;
      cyc++;
    end
    check("stream_count", got_q.size(), n);
    @(negedge Clk);
    idle_inputs(k);
    check("stream_word_cnt", {16'd0, word_cnt[k]}, n);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0]  st;
    logic [14:0] r;
    logic [7:0]  w0;

    for (int k = 0; k < NI; k++) begin
      idle_inputs(k);
      rst[k] = 1'b1;
    end

    //               iv   id     ordy  fs    sl    si     ov    od     cnt
    tbl[0]  = '{1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 7'h00, 1'b1, 8'h70, 16'd0};
    tbl[1]  = '{1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, 7'h00, 1'b1, 8'hB0, 16'd1};
    tbl[2]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 7'h00, 1'b0, 8'h00, 16'd2};
    tbl[3]  = '{1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 7'h00, 1'b1, 8'h93, 16'd2};
    tbl[4]  = '{1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 7'h00, 1'b1, 8'h93, 16'd2};
    tbl[5]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 7'h00, 1'b1, 8'h93, 16'd2};
    tbl[6]  = '{1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 7'h00, 1'b1, 8'h40, 16'd3};
    tbl[7]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 7'h00, 1'b0, 8'h00, 16'd4};
    tbl[8]  = '{1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 7'h00, 1'b1, 8'h70, 16'd0};
    tbl[9]  = '{1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 7'h00, 1'b1, 8'h4F, 16'd1};
    tbl[10] = '{1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 7'h2A, 1'b1, 8'h93, 16'd2};
    tbl[11] = '{1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 7'h00, 1'b1, 8'h5F, 16'd3};
    tbl[12] = '{1'b1, 8'h00, 1'b1, 1'b1, 1'b1, 7'h00, 1'b1, 8'h5F, 16'd0};
    tbl[13] = '{1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 7'h00, 1'b1, 8'h00, 16'd1};
    tbl[14] = '{1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 7'h00, 1'b1, 8'hA5, 16'd2};
    tbl[15] = '{1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 7'h7F, 1'b1, 8'h00, 16'd3};
    tbl[16] = '{1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 7'h00, 1'b1, 8'h70, 16'd0};
    tbl[17] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 7'h00, 1'b0, 8'h00, 16'd1};

    repeat (3) @(posedge Clk);
    @(negedge Clk);
    for (int k = 0; k < NI; k++) rst[k] = 1'b0;
    #1;
    check("rst_out_valid", {31'd0, out_valid[0]}, 32'd0);
    check("rst_out_data", {24'd0, out_data[0]}, 32'd0);
    check("rst_word_cnt", {16'd0, word_cnt[0]}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready[0]}, 32'd1);

    // Directed table on the additive instance.
    for (int i = 0; i < 18; i++) begin
      @(negedge Clk);
      in_valid[0]    = tbl[i].iv;
      in_data[0]     = tbl[i].id;
      out_ready[0]   = tbl[i].ordy;
      frame_start[0] = tbl[i].fs;
      seed_load[0]   = tbl[i].sl;
      seed_in[0]     = tbl[i].si;
      @(posedge Clk);
      #1;
      check($sformatf("tbl%0d_valid", i), {31'd0, out_valid[0]}, {31'd0, tbl[i].ov});
      if (tbl[i].ov) check($sformatf("tbl%0d_data", i), {24'd0, out_data[0]}, {24'd0, tbl[i].od});
      check($sformatf("tbl%0d_cnt", i), {16'd0, word_cnt[0]}, {16'd0, tbl[i].cnt});
    end

    // Reset while a word is stalled at the output.
    @(negedge Clk);
    idle_inputs(0);
    in_valid[0]  = 1'b1;
    out_ready[0] = 1'b0;
    @(posedge Clk);
    #1;
    check("pre_rst_data", {24'd0, out_data[0]}, 32'h4F);
    check("pre_rst_cnt", {16'd0, word_cnt[0]}, 32'd1);
    @(negedge Clk);
    rst[0] = 1'b1;
    @(posedge Clk);
    #1;
    check("stall_rst_valid", {31'd0, out_valid[0]}, 32'd0);
    check("stall_rst_data", {24'd0, out_data[0]}, 32'd0);
    check("stall_rst_cnt", {16'd0, word_cnt[0]}, 32'd0);
    @(negedge Clk);
    rst[0] = 1'b0;
    in_valid[0] = 1'b0;
    out_ready[0] = 1'b1;
    #1;
    check("post_rst_in_ready", {31'd0, in_ready[0]}, 32'd1);
    @(negedge Clk);
    in_valid[0] = 1'b1;
    in_data[0]  = 8'h00;
    @(posedge Clk);
    #1;
    check("post_rst_first_word", {24'd0, out_data[0]}, 32'h70);
    check("post_rst_first_valid", {31'd0, out_valid[0]}, 32'd1);
    @(negedge Clk);
    idle_inputs(0);

    // Keystream period: 128 zero words; 127*8 bits is a whole number of periods.
    do_reset(0);
    src_q.delete();
    for (int i = 0; i < 128; i++) src_q.push_back(8'h00);
    run_stream(0, 128, 1'b0, 1'b0);
    st = 7'h7F;
    for (int i = 0; i < got_q.size(); i++) begin
      r  = mdl_step(0, st, src_q[i]);
      st = r[14:8];
      check($sformatf("keystream_w%0d", i), {24'd0, got_q[i]}, {24'd0, r[7:0]});
    end
    if (got_q.size() == 128) begin
      w0 = got_q[0];
      check("period_127", {24'd0, got_q[127]}, {24'd0, w0});
    end

    // Additive scramble with random backpressure, then descramble on a second instance.
    do_reset(0);
    do_reset(1);
    src_q.delete();
    for (int i = 0; i < 200; i++) src_q.push_back(8'($urandom));
    orig_q = src_q;
    run_stream(0, 200, 1'b1, 1'b1);
    st = 7'h7F;
    for (int i = 0; i < got_q.size(); i++) begin
      r  = mdl_step(0, st, src_q[i]);
      st = r[14:8];
      check($sformatf("add_scr_w%0d", i), {24'd0, got_q[i]}, {24'd0, r[7:0]});
    end
    src_q = got_q;
    run_stream(1, 200, 1'b1, 1'b1);
    for (int i = 0; i < got_q.size(); i++)
      check($sformatf("add_roundtrip_w%0d", i), {24'd0, got_q[i]}, {24'd0, orig_q[i]});

    // Multiplicative scramble, then self-synchronising descramble from a wrong seed.
    do_reset(2);
    do_reset(3);
    src_q.delete();
    for (int i = 0; i < 100; i++) src_q.push_back(8'($urandom));
    orig_q = src_q;
    run_stream(2, 100, 1'b1, 1'b0);
    st = 7'h7F;
    for (int i = 0; i < got_q.size(); i++) begin
      r  = mdl_step(1, st, src_q[i]);
      st = r[14:8];
      check($sformatf("mul_scr_w%0d", i), {24'd0, got_q[i]}, {24'd0, r[7:0]});
    end
    scr_q = got_q;
    @(negedge Clk);
    seed_load[3] = 1'b1;
    seed_in[3]   = 7'h00;
    @(negedge Clk);
    seed_load[3] = 1'b0;
    src_q = scr_q;
    run_stream(3, 100, 1'b1, 1'b0);
    for (int i = 0; i < got_q.size(); i++) begin
      if (i == 0)
        check("mul_dsc_w0_bit7", {24'd0, got_q[0] & 8'h80}, {24'd0, orig_q[0] & 8'h80});
      else
        check($sformatf("mul_dsc_w%0d", i), {24'd0, got_q[i]}, {24'd0, orig_q[i]});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
